// File: rtl/layer_sequencer_pkg.sv
// Shared instruction-memory geometry and the layer sequencer state type.
package parameters;

    localparam int INSTRUCTION_MEMORY_SIZE   = 32;
    localparam int INSTRUCTION_MEMORY_FIELDS = 24;
    localparam int INSTRUCTION_MEMORY_WIDTH  = 16;

    localparam int LAYER_CNT_W = $clog2(INSTRUCTION_MEMORY_SIZE) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_RUN,
        ST_WAIT_DONE,
        ST_NEXT,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/layer_sequencer.sv
// Steps the instruction memory through num_layers layers, registering each
// layer's fields and handing it to the MAC engine with a start/done handshake.
module layer_sequencer
    import parameters::*;
#(
    parameter int INSTRUCTION_MEMORY_SIZE   = parameters::INSTRUCTION_MEMORY_SIZE,
    parameter int INSTRUCTION_MEMORY_FIELDS = parameters::INSTRUCTION_MEMORY_FIELDS,
    parameter int INSTRUCTION_MEMORY_WIDTH  = parameters::INSTRUCTION_MEMORY_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [$clog2(INSTRUCTION_MEMORY_SIZE):0] num_layers,
    input  logic [INSTRUCTION_MEMORY_WIDTH-1:0]   instruction  [INSTRUCTION_MEMORY_FIELDS],
    input  logic                                  layer_done,
    output logic [31:0]                           PC,
    output logic [INSTRUCTION_MEMORY_WIDTH-1:0]   layer_config [INSTRUCTION_MEMORY_FIELDS],
    output logic                                  layer_start,
    output logic                                  busy,
    output logic                                  finished
);

    localparam int CNT_W = $clog2(INSTRUCTION_MEMORY_SIZE) + 1;
    localparam int PC_W  = CNT_W - 1;

    seq_state_t        state_q, state_d;
    logic [PC_W-1:0]   pc_q;
    logic [CNT_W-1:0]  n_lat_q;
    logic [CNT_W-1:0]  n_clamped;
    logic              last_layer;

    assign n_clamped  = (num_layers > CNT_W'(INSTRUCTION_MEMORY_SIZE))
                        ? CNT_W'(INSTRUCTION_MEMORY_SIZE) : num_layers;
    assign last_layer = ({1'b0, pc_q} == (n_lat_q - CNT_W'(1)));
    assign PC         = 32'(pc_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        layer_start = 1'b0;
        finished    = 1'b0;
        busy        = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (n_clamped == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_RUN;
            ST_RUN: begin
                layer_start = 1'b1;
                state_d     = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (layer_done) begin
                    state_d = last_layer ? ST_DONE : ST_NEXT;
                end
            end
            ST_NEXT: state_d = ST_FETCH;
            ST_DONE: begin
                finished = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // layer_config is deliberately left untouched outside LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            n_lat_q <= '0;
            for (int unsigned i = 0; i < INSTRUCTION_MEMORY_FIELDS; i++) begin
                layer_config[i] <= '0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        n_lat_q <= n_clamped;
                        pc_q    <= '0;
                    end
                end
                ST_LOAD: begin
                    for (int unsigned i = 0; i < INSTRUCTION_MEMORY_FIELDS; i++) begin
                        layer_config[i] <= instruction[i];
                    end
                end
                ST_NEXT: pc_q <= pc_q + PC_W'(1);
                ST_DONE: pc_q <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: driver predicts the layer/finish event
// stream from the program rules, a negedge monitor checks what the DUT presents.
module tb_layer_sequencer;

    import parameters::*;

    localparam int SIZE   = 32;
    localparam int FIELDS = 24;
    localparam int WIDTH  = 16;
    localparam int CFG_W  = FIELDS * WIDTH;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic [LAYER_CNT_W-1:0] num_layers;
    logic [WIDTH-1:0]       instruction  [FIELDS];
    logic                   layer_done;
    logic [31:0]            PC;
    logic [WIDTH-1:0]       layer_config [FIELDS];
    logic                   layer_start;
    logic                   busy;
    logic                   finished;

    logic [WIDTH-1:0]       mem [SIZE][FIELDS];

    int                     n_tests;
    int                     n_fail;

    int                     exp_kind [$];   // 0 = layer_start, 1 = finished
    int                     exp_pc   [$];   // -1 = don't care
    logic [CFG_W-1:0]       exp_cfg  [$];

    layer_sequencer #(
        .INSTRUCTION_MEMORY_SIZE  (SIZE),
        .INSTRUCTION_MEMORY_FIELDS(FIELDS),
        .INSTRUCTION_MEMORY_WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_layers  (num_layers),
        .instruction (instruction),
        .layer_done  (layer_done),
        .PC          (PC),
        .layer_config(layer_config),
        .layer_start (layer_start),
        .busy        (busy),
        .finished    (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory read
    always_comb begin
        for (int f = 0; f < FIELDS; f++) begin
            instruction[f] = (PC < 32'(SIZE)) ? mem[PC[4:0]][f] : '0;
        end
    end

    function automatic void check(input bit ok, input string name,
                                  input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    function automatic logic [CFG_W-1:0] pack_mem(input int k);
        logic [CFG_W-1:0] v;
        for (int f = 0; f < FIELDS; f++) v[f*WIDTH +: WIDTH] = mem[k][f];
        return v;
    endfunction

    function automatic logic [CFG_W-1:0] pack_cfg();
        logic [CFG_W-1:0] v;
        for (int f = 0; f < FIELDS; f++) v[f*WIDTH +: WIDTH] = layer_config[f];
        return v;
    endfunction

    function automatic void fill_mem(input bit fixed_f0);
        for (int k = 0; k < SIZE; k++) begin
            for (int f = 0; f < FIELDS; f++) mem[k][f] = WIDTH'($urandom);
            if (fixed_f0) mem[k][0] = WIDTH'(16'h100 + k);
        end
    endfunction

    // Monitor: every layer_start / finished the DUT presents must match the next predicted event
    always @(negedge clk) begin
        if (reset) begin
            if (layer_start) begin
                check(PC <= 32'(SIZE - 1), "pc_max", PC, SIZE - 1);
                if (exp_kind.size() == 0 || exp_kind[0] != 0) begin
                    check(1'b0, "unexpected_layer_start", PC, 0);
                end else begin
                    int               k;
                    int               p;
                    logic [CFG_W-1:0] c;
                    k = exp_kind.pop_front();
                    p = exp_pc.pop_front();
                    c = exp_cfg.pop_front();
                    check(PC == 32'(p), "layer_pc", PC, p);
                    check(pack_cfg() == c, "layer_config", pack_cfg(), c);
                end
            end
            if (finished) begin
                if (exp_kind.size() == 0 || exp_kind[0] != 1) begin
                    check(1'b0, "unexpected_finished", 1, 0);
                end else begin
                    int k;
                    int p;
                    k = exp_kind.pop_front();
                    p = exp_pc.pop_front();
                    void'(exp_cfg.pop_front());
                    if (p >= 0) check(PC == 32'(p), "finished_pc", PC, p);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_event(output int cnt);
        cnt = 1;
        while (!layer_start && !finished && cnt < 20) begin
            step();
            cnt++;
        end
    endtask

    // One program run; returns on the first IDLE cycle after finished (or after an abort)
    task automatic run_program(input int num, input int gap_lo, input int gap_hi,
                               input bit noise, input int abort_at);
        int n;
        int cnt;
        int gap;
        n = (num > SIZE) ? SIZE : num;
        for (int k = 0; k < n; k++) begin
            exp_kind.push_back(0);
            exp_pc.push_back(k);
            exp_cfg.push_back(pack_mem(k));
        end
        exp_kind.push_back(1);
        exp_pc.push_back((n == 0) ? 0 : -1);
        exp_cfg.push_back('0);

        if (noise) begin
            layer_done = 1'b1;
            step();
            layer_done = 1'b0;
        end
        start      = 1'b1;
        num_layers = LAYER_CNT_W'(num);
        step();
        start = 1'b0;
        wait_event(cnt);
        if (n == 0) begin
            check(finished && cnt == 1, "zero_finish_latency", cnt, 1);
            check(PC == 0, "zero_pc", PC, 0);
            step();
            check(!busy, "zero_busy_after", busy, 0);
            return;
        end
        check(layer_start && cnt == 3, "start_latency", cnt, 3);
        if (!layer_start) return;

        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                step();
                reset = 1'b0;
                #1;
                check(PC == 0, "abort_pc", PC, 0);
                check(!busy, "abort_busy", busy, 0);
                check(!layer_start && !finished, "abort_pulses", {layer_start, finished}, 0);
                check(pack_cfg() == '0, "abort_config", pack_cfg(), 0);
                exp_kind.delete();
                exp_pc.delete();
                exp_cfg.delete();
                repeat (3) step();
                reset = 1'b1;
                step();
                return;
            end
            gap = $urandom_range(gap_hi, gap_lo);
            if (noise) layer_done = 1'b1;
            for (int g = 1; g <= gap; g++) begin
                step();
                start      = noise && (g < gap);
                layer_done = (g == gap);
            end
            step();
            layer_done = 1'b0;
            start      = 1'b0;
            wait_event(cnt);
            if (k < n - 1) begin
                check(layer_start && cnt == 4, "next_latency", cnt, 4);
            end else begin
                check(finished && cnt == 1, "finish_latency", cnt, 1);
            end
            if (!layer_start && !finished) return;
        end
        step();
        check(!busy, "busy_after", busy, 0);
        check(PC == 0, "pc_after", PC, 0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b0;
        start      = 1'b0;
        layer_done = 1'b0;
        num_layers = '0;
        fill_mem(1'b1);
        repeat (3) step();
        check(PC == 0, "reset_pc", PC, 0);
        check(!busy && !layer_start && !finished, "reset_flags",
              {busy, layer_start, finished}, 0);
        check(pack_cfg() == '0, "reset_config", pack_cfg(), 0);
        reset = 1'b1;
        step();

        run_program(3, 2, 2, 1'b0, -1);
        run_program(0, 1, 1, 1'b0, -1);
        run_program(40, 1, 1, 1'b0, -1);
        fill_mem(1'b0);
        run_program(3, 2, 3, 1'b1, -1);
        run_program(3, 1, 3, 1'b0, 1);
        run_program(3, 1, 2, 1'b0, -1);
        run_program(2, 1, 1, 1'b0, -1);
        run_program(2, 1, 1, 1'b0, -1);
        for (int i = 0; i < 8; i++) begin
            fill_mem(1'b0);
            run_program($urandom_range(40, 0), 1, 4, 1'($urandom_range(1, 0)), -1);
        end
        repeat (2) step();
        check(exp_kind.size() == 0, "scoreboard_drained", exp_kind.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Program sequencer that sits directly downstream of the instruction memory. It drives the memory's `PC` read index and captures the selected layer's instruction fields into a stable configuration register. It then hands each layer to the MAC engine control with a start/done handshake and steps through `num_layers` layers. It raises a one-cycle `finished` pulse when the program completes.

## Interface
Parameters:
- `INSTRUCTION_MEMORY_SIZE`, default 32 (from `parameters`): maximum layers held in the instruction memory.
- `INSTRUCTION_MEMORY_FIELDS`, default 24 (from `parameters`): configuration fields per layer.
- `INSTRUCTION_MEMORY_WIDTH`, default 16 (from `parameters`): bits per field.

Ports:
- `clk`: input, 1 bit. The single clock.
- `reset`: input, 1 bit. Asynchronous, active-low reset.
- `start`: input, 1 bit. Begin program execution. Sampled only in IDLE.
- `num_layers`: input, `$clog2(INSTRUCTION_MEMORY_SIZE)+1` bits. Layer count, sampled with `start`.
- `instruction`: input, `[INSTRUCTION_MEMORY_WIDTH-1:0] x [INSTRUCTION_MEMORY_FIELDS]`. Combinational read data from the instruction memory at `PC`.
- `layer_done`: input, 1 bit. The engine has finished the current layer. Sampled only in WAIT_DONE.
- `PC`: output, 32 bits. Instruction memory read index.
- `layer_config`: output, same shape as `instruction`. Registered fields of the current layer.
- `layer_start`: output, 1 bit. One-cycle pulse; `layer_config` is valid on it.
- `busy`: output, 1 bit. High in every state except IDLE.
- `finished`: output, 1 bit. One-cycle pulse at program end.

## Operation
- FSM states are IDLE, FETCH, LOAD, RUN, WAIT_DONE, NEXT, DONE.
- IDLE:
  - On `start`=1, latch `n_lat` = min(`num_layers`, `INSTRUCTION_MEMORY_SIZE`) and set `PC`=0.
  - If `n_lat`=0, go to DONE; otherwise go to FETCH.
- FETCH: one settle cycle for the combinational memory read. Go to LOAD.
- LOAD: `layer_config <= instruction`, all fields in one cycle. Go to RUN.
- RUN: `layer_start`=1 for exactly this cycle. Go to WAIT_DONE.
- WAIT_DONE: hold until `layer_done`=1.
  - If `PC` == `n_lat`-1, go to DONE.
  - Otherwise go to NEXT.
- NEXT: `PC <= PC+1`. Go to FETCH.
- DONE: `finished`=1 for this cycle. `PC` resets to 0. Go to IDLE.
- `layer_config` holds its value from LOAD until the next LOAD. It is not cleared in IDLE or DONE.
- `PC` upper bits beyond `$clog2(INSTRUCTION_MEMORY_SIZE)` are always 0. No wrap-around is possible because of the clamp.
- `start` asserted while `busy` is ignored and not queued.
- `layer_done` asserted outside WAIT_DONE, including in the `layer_start` cycle itself, is ignored.

## Timing
- Reset values: state IDLE, `PC`=0, `n_lat`=0, `layer_config` all zero. `layer_start`, `busy`, `finished` are 0.
- `layer_start`, `busy` and `finished` are decoded from the registered state only, with no input-to-output combinational path.
- Latency from `start` (cycle t) to `layer_start` is 3 cycles: FETCH at t+1, LOAD at t+2, RUN at t+3.
- Latency from `layer_done` (cycle d) to the next `layer_start` is 4 cycles: NEXT d+1, FETCH d+2, LOAD d+3, RUN d+4.
- After the last layer's `layer_done` at cycle d, `finished`=1 at d+1 and IDLE is reached at d+2. A new `start` is accepted from d+2.
- With `num_layers`=0 and `start` at t: DONE at t+1 with `finished`=1; no `layer_start` is issued.
- Minimum period per layer is 5 cycles, when `layer_done` arrives in the first WAIT_DONE cycle.
- Reset asserted mid-operation returns to IDLE immediately, with all outputs at their reset values. A pending layer is abandoned and no `finished` is issued.

## Structure
- The existing `parameters` package gains:
  - typedef `seq_state_t`, a 3-bit enum of the seven states;
  - localparam `LAYER_CNT_W` = `$clog2(INSTRUCTION_MEMORY_SIZE)+1`.
- Implementation is a single module: one state register process and one datapath process for `PC`, `n_lat` and `layer_config`.
- No sub-module is needed.
- The `instruction`/`layer_config` port shape matches the instruction memory's output exactly, so the two connect directly.

## Test plan
- Reset then `start`, `num_layers`=3, memory field 0 of layer k = 0x100+k, `layer_done` 2 cycles after each `layer_start`:
  - `PC` sequences 0, 1, 2;
  - `layer_config[0]` = 0x100, 0x101, 0x102 on each `layer_start`;
  - exactly 3 `layer_start` pulses, then 1 `finished` pulse;
  - `busy` is 0 afterwards.
- `num_layers`=0: `finished` one cycle after `start`, no `layer_start`, `PC` stays 0.
- `num_layers`=40 with SIZE=32: the run clamps to 32 layers; the last `layer_start` has `PC`=31, and `PC` never exceeds 31.
- `start` pulsed during WAIT_DONE, and `layer_done` pulsed during RUN and IDLE: no effect on the sequence or on the layer count.
- `reset` dropped during WAIT_DONE of layer 1 of 3: outputs return to their reset values the same cycle, and no `finished` is issued. A subsequent `start` runs all 3 layers from `PC`=0.
- Back-to-back programs, with `start` asserted on the first IDLE cycle after `finished`: the second run is accepted with latency 3 to `layer_start`.
